// File: rtl/reg_dump_controller.sv
// reg_dump_controller
// Debug-side sequencer that walks the whole register bank through its debug
// read port and streams every word out LSB byte first on a valid/ready byte
// interface. Runs only while the pipeline is halted.
//
// Optional feature macro: REG_DUMP_CHECKSUM_EN
//   When defined, a running XOR of every accepted data byte is appended as
//   one extra byte after the last data byte.
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset        synchronous active-high reset
//   i_start        dump request, sampled only in idle
//   i_reg_data     bank read data (bank o_data_a)
//   o_read_enable  bank read enable (bank i_read_enable)
//   o_read_addr    bank read address (bank i_read_addr)
//   o_tx_data      byte to transmit
//   o_tx_valid     o_tx_data is valid
//   i_tx_ready     sink accepts the byte this cycle
//   o_busy         dump in progress
//   o_done         one-cycle pulse when a dump completes
module reg_dump_controller #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned ADDR_SIZE  = 5,
    parameter int unsigned BANK_DEPTH = 32,
    parameter int unsigned BYTE_SIZE  = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [DATA_SIZE-1:0] i_reg_data,
    output logic                 o_read_enable,
    output logic [ADDR_SIZE-1:0] o_read_addr,
    output logic [BYTE_SIZE-1:0] o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned BytesPerWord = DATA_SIZE / BYTE_SIZE;
    localparam int unsigned IdxW = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
    localparam logic [IdxW-1:0]      LastIdx  = IdxW'(BytesPerWord - 1);
    localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(BANK_DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StLatch = 3'd2,
        StSend  = 3'd3,
        StDone  = 3'd4
`ifdef REG_DUMP_CHECKSUM_EN
        ,
        StCsum  = 3'd5
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_SIZE-1:0] word_q, word_d;
    logic [BYTE_SIZE-1:0] cur_byte;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [BYTE_SIZE-1:0] csum_q, csum_d;
`endif

    assign cur_byte = word_q[int'(idx_q) * BYTE_SIZE +: BYTE_SIZE];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        word_d  = word_q;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StRead;
                    addr_d  = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            // Bank registers the word on this edge; it is visible in StLatch.
            StRead:  state_d = StLatch;
            StLatch: begin
                word_d  = i_reg_data;
                idx_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                if (i_tx_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d = csum_q ^ cur_byte;
`endif
                    if (idx_q == LastIdx) begin
                        if (addr_q == LastAddr) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            state_d = StCsum;
`else
                            state_d = StDone;
`endif
                        end else begin
                            addr_d  = addr_q + ADDR_SIZE'(1);
                            state_d = StRead;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            StCsum: begin
                if (i_tx_ready) begin
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend only on registered state; i_tx_ready never reaches them.
    always_comb begin
        o_read_enable = (state_q == StRead);
        o_read_addr   = addr_q;
        o_tx_valid    = (state_q == StSend);
        o_tx_data     = (state_q == StSend) ? cur_byte : '0;
        o_busy        = (state_q == StRead) || (state_q == StLatch) || (state_q == StSend);
        o_done        = (state_q == StDone);
`ifdef REG_DUMP_CHECKSUM_EN
        if (state_q == StCsum) begin
            o_tx_valid = 1'b1;
            o_tx_data  = csum_q;
            o_busy     = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_reg_dump_controller.sv
// Self-checking bench for reg_dump_controller. Models the register bank with a
// registered read port and checks the byte stream, read-port protocol, done
// timing, back-pressure, start-while-busy and reset abort.
module tb_reg_dump_controller;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CsumExtra = 1;
    localparam int CsumLast  = 'hFF;
`else
    localparam int CsumExtra = 0;
    localparam int CsumLast  = 'h00;
`endif
    localparam int RunCycles = 230;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_reg_data;
    logic        o_read_enable;
    logic [4:0]  o_read_addr;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_done;

    reg_dump_controller dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_reg_data    (i_reg_data),
        .o_read_enable (o_read_enable),
        .o_read_addr   (o_read_addr),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 i_clock = ~i_clock;

    // Bank model: registered debug read port.
    logic [31:0] bank [32];
    always @(posedge i_clock) begin
        if (o_read_enable) i_reg_data <= bank[o_read_addr];
    end

    typedef struct {
        string name;
        int    bank_mode;   // 0: incrementing pattern, 1: checksum pattern
        int    stall_at;    // first cycle with ready low (0 = none)
        int    stall_len;
        int    xs1;         // extra start pulse cycles (0 = none)
        int    xs2;
        int    exp_done;    // cycle of o_done without checksum
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] exp_q [$];
    int         n_vec = 0;
    int         n_bad = 0;

    // Results of the last run_dump.
    int acc, data_err, rd_cnt, addr_err, done_cnt, done_cyc, last_byte;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic fill_bank(input int mode);
        logic [7:0] x;
        for (int k = 0; k < 32; k++) begin
            if (mode == 0) bank[k] = 32'h0403_0201 + k * 32'h0404_0404;
            else           bank[k] = 32'h0;
        end
        if (mode == 1) begin
            bank[3] = 32'h0000_00A5;
            bank[9] = 32'h5A00_0000;
        end
        exp_q.delete();
        x = 8'h00;
        for (int k = 0; k < 32; k++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(bank[k][8*b +: 8]);
                x = x ^ bank[k][8*b +: 8];
            end
        end
        if (CsumExtra != 0) exp_q.push_back(x);
    endtask

    // Called just after a rising edge; cycle n is the n-th cycle after the
    // edge that samples i_start.
    task automatic run_dump(input int stall_at, input int stall_len, input int xs1,
                            input int xs2);
        acc = 0; data_err = 0; rd_cnt = 0; addr_err = 0;
        done_cnt = 0; done_cyc = 0; last_byte = -1;
        i_start = 1'b1;
        @(posedge i_clock); #1;
        for (int n = 1; n <= RunCycles; n++) begin
            i_start    = (n == xs1) || (n == xs2);
            i_tx_ready = !(stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
            @(negedge i_clock);
            if (o_read_enable) begin
                if (int'(o_read_addr) != rd_cnt) addr_err++;
                rd_cnt++;
            end
            if (o_tx_valid) begin
                if (acc >= exp_q.size() || o_tx_data != exp_q[acc]) data_err++;
                if (i_tx_ready) begin
                    last_byte = o_tx_data;
                    acc++;
                end
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n;
            end
            @(posedge i_clock); #1;
        end
        i_start    = 1'b0;
        i_tx_ready = 1'b1;
    endtask

    initial begin
        int quiet;
        vecs[0] = '{"basic",      0, 0,  0, 0,  0,   193};
        vecs[1] = '{"backpress",  0, 47, 5, 0,  0,   198};
        vecs[2] = '{"start_busy", 0, 0,  0, 10, 100, 193};
        vecs[3] = '{"csum_pat",   1, 0,  0, 0,  0,   193};

        i_reset = 1'b1; i_start = 1'b0; i_tx_ready = 1'b1;
        fill_bank(0);
        repeat (3) @(posedge i_clock);
        #1 i_reset = 1'b0;
        @(negedge i_clock);
        check("reset_outputs",
              {o_read_enable, o_read_addr, o_tx_data, o_tx_valid, o_busy, o_done}, 0);
        @(posedge i_clock); #1;

        // Reset in cycle 50 of a dump; the first table vector then shows a
        // fresh start dumping from address 0.
        i_start = 1'b1;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        repeat (49) begin @(posedge i_clock); #1; end
        check("busy_before_reset", o_busy, 1);
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        @(negedge i_clock);
        check("reset_abort_outputs",
              {o_read_enable, o_read_addr, o_tx_data, o_tx_valid, o_busy, o_done}, 0);
        quiet = 0;
        repeat (20) begin
            @(negedge i_clock);
            if (o_tx_valid || o_done || o_busy) quiet++;
        end
        check("reset_abort_quiet", quiet, 0);
        @(posedge i_clock); #1;

        for (int v = 0; v < 4; v++) begin
            fill_bank(vecs[v].bank_mode);
            run_dump(vecs[v].stall_at, vecs[v].stall_len, vecs[v].xs1, vecs[v].xs2);
            check({vecs[v].name, "_byte_count"}, acc, 128 + CsumExtra);
            check({vecs[v].name, "_byte_data"}, data_err, 0);
            check({vecs[v].name, "_done_cycle"}, done_cyc, vecs[v].exp_done + CsumExtra);
            check({vecs[v].name, "_done_pulses"}, done_cnt, 1);
            check({vecs[v].name, "_read_pulses"}, rd_cnt, 32);
            check({vecs[v].name, "_read_addr"}, addr_err, 0);
            if (vecs[v].bank_mode == 1) check("csum_last_byte", last_byte, CsumLast);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_controller.md
# reg_dump_controller

Debug-side sequencer that dumps the whole register bank over a byte stream. On a start request it walks every bank address through the bank's debug read port, captures each word, and emits it least-significant byte first on a valid/ready byte interface toward the debug unit's UART transmitter. It sits between the debug unit and the ID-stage register bank. It runs only while the pipeline is halted, with the bank's `i_enable` low.

## Interface
- `DATA_SIZE`, 32: bank word width; must be a multiple of `BYTE_SIZE`.
- `ADDR_SIZE`, 5: bank address width.
- `BANK_DEPTH`, 32: number of registers dumped, addresses 0..BANK_DEPTH-1.
- `BYTE_SIZE`, 8: width of the output stream.

- `i_clock`  in  1  the single clock; all logic is rising-edge.
- `i_reset`  in  1  synchronous reset, active-high.
- `i_start`  in  1  dump request, sampled only in IDLE.
- `i_reg_data`  in  DATA_SIZE  connects to the bank's `o_data_a`.
- `o_read_enable`  out  1  connects to the bank's `i_read_enable`.
- `o_read_addr`  out  ADDR_SIZE  connects to the bank's `i_read_addr`.
- `o_tx_data`  out  BYTE_SIZE  byte to transmit.
- `o_tx_valid`  out  1  `o_tx_data` is valid.
- `i_tx_ready`  in  1  the sink accepts the byte this cycle.
- `o_busy`  out  1  a dump is in progress.
- `o_done`  out  1  one-cycle pulse when a dump completes.

## Operation
- States and transitions:
  - IDLE: goes to READ when `i_start`=1.
  - READ: goes to LATCH.
  - LATCH: goes to SEND.
  - SEND: on each accepted byte, increment the byte index. After the last byte of a word, go to READ with addr+1. After the last byte of the last word, go to CSUM if the checksum feature is built in, otherwise to DONE.
  - CSUM: goes to DONE once the checksum byte is accepted.
  - DONE: goes to IDLE.
- READ:
  - Drives `o_read_enable`=1 and `o_read_addr`=current address.
  - The bank registers the word on that edge.
- LATCH:
  - `o_read_enable`=0.
  - Captures `i_reg_data` into an internal word register.
  - Byte index is cleared to 0.
- SEND:
  - `o_tx_valid`=1.
  - `o_tx_data` = word[(idx+1)*BYTE_SIZE-1 : idx*BYTE_SIZE], so the LSB byte goes first.
  - Bytes per word = DATA_SIZE/BYTE_SIZE.
- Handshake:
  - A byte transfers on a rising edge where `o_tx_valid`&&`i_tx_ready`.
  - While valid and not ready, `o_tx_data` and the state are held stable.
  - `o_tx_valid` is never dropped before acceptance.
- Address counter:
  - Width ADDR_SIZE; counts 0..BANK_DEPTH-1.
  - Does not wrap to continue past the last address.
  - Clears to 0 on entering READ from IDLE.
- `o_busy`=1 in READ, LATCH, SEND and CSUM; 0 in IDLE and DONE.
- `o_done`=1 only in DONE, for exactly one cycle.
- `i_start` while busy or in DONE is ignored; it is not queued.
- `i_reg_data` is ignored outside LATCH.

## Timing
- Reset:
  - State=IDLE, address=0, byte index=0, word register=0, checksum=0.
  - Outputs: `o_read_enable`=0, `o_read_addr`=0, `o_tx_data`=0, `o_tx_valid`=0, `o_busy`=0, `o_done`=0.
  - Reset mid-dump aborts immediately; no further bytes and no `o_done` pulse.
- All outputs are decoded from registered state; there is no combinational path from `i_tx_ready` to any output.
- Start sampled at edge E0:
  - READ occupies cycle 1, LATCH cycle 2.
  - The first byte is valid from cycle 3.
- With `i_tx_ready` held at 1:
  - Each word takes 2 + DATA_SIZE/BYTE_SIZE cycles, i.e. 6 at the defaults.
  - At the defaults the last data byte is accepted at the end of cycle 192.
  - DONE is cycle 193 without the checksum, cycle 194 with it.
- A back-pressure stall of N cycles delays every later event by exactly N cycles.

## Configuration
- `REG_DUMP_CHECKSUM_EN` defined:
  - A BYTE_SIZE-bit running XOR of every accepted data byte is kept.
  - The checksum clears when leaving IDLE.
  - CSUM emits it as one extra byte with `o_tx_valid`=1 and the same handshake rules.
- `REG_DUMP_CHECKSUM_EN` undefined:
  - No CSUM state and no checksum register.
  - SEND goes straight to DONE after the final byte.

## Test plan
- Basic dump, ready=1:
  - Stimulus: reg[k]=32'h0403_0201 + k*32'h0404_0404; pulse `i_start`.
  - Response: 128 bytes 01,02,03,04,05,06,07,08,... in order; `o_done` pulses at cycle 193.
- Back-pressure:
  - Stimulus: ready low 5 cycles during byte 2 of reg 7.
  - Response: `o_tx_data` stays stable at the byte-2 value for those 5 cycles; no byte lost or duplicated; done is 5 cycles later.
- Read-port protocol:
  - Check `o_read_enable` is high for exactly 1 cycle per word, 32 pulses total.
  - Check `o_read_addr` steps 0..31, each pulse one cycle before LATCH.
- Start during busy:
  - Stimulus: extra `i_start` pulses at cycles 10 and 100.
  - Response: a single 128-byte dump and a single `o_done`.
- Reset mid-dump:
  - Stimulus: `i_reset` at cycle 50.
  - Response: next cycle all outputs are 0 and the state is IDLE; a new start dumps from address 0.
- Checksum (`REG_DUMP_CHECKSUM_EN`):
  - Stimulus: all regs zero except reg[3]=32'h0000_00A5 and reg[9]=32'h5A00_0000.
  - Response: 129th byte = 8'hFF.
